// File: rtl/i2c_register_master.sv
// Single-master I2C initiator: one 8-bit register write, or a register read using a
// repeated start, per accepted request. Open-drain SCL/SDA via output enables.
module i2c_register_master #(
    parameter int CLK_DIV = 135
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       ready,
    output logic       done,
    output logic       ack_error,
    output logic [7:0] rdata,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_in,
    input  logic       sda_in
);
    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] QMAX = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_TX, S_RXACK, S_RSTART, S_RX, S_TXNACK, S_STOP
    } state_t;

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_qcnt;
    logic [1:0]    r_ph, w_ph_nx;
    logic [2:0]    r_bit, w_bit_nx;
    logic [1:0]    r_byte, w_byte_nx;
    logic [7:0]    r_shift, w_shift_nx;
    logic          r_rw;
    logic [6:0]    r_dev;
    logic [7:0]    r_reg, r_wdata, r_rx, r_rdata;
    logic          r_nack, r_ack_err, r_done, r_scl_oe, r_sda_oe;
    logic          w_tick, w_nack_stop, w_done_nx, w_scl_nx, w_sda_nx;

    assign w_tick    = (r_qcnt == QMAX);
    assign ready     = (r_state == S_IDLE);
    assign done      = r_done;
    assign ack_error = r_ack_err;
    assign rdata     = r_rdata;
    assign scl_oe    = r_scl_oe;
    assign sda_oe    = r_sda_oe;

    always_comb begin
        w_state_nx  = r_state;
        w_ph_nx     = r_ph;
        w_bit_nx    = r_bit;
        w_byte_nx   = r_byte;
        w_shift_nx  = r_shift;
        w_nack_stop = 1'b0;
        w_done_nx   = 1'b0;
        case (r_state)
            S_IDLE: if (start) begin
                w_state_nx = S_START;
                w_ph_nx    = 2'd0;
            end
            S_START: if (w_tick) begin
                if (r_ph == 2'd0) begin
                    if (scl_in) w_ph_nx = 2'd1;
                end else begin
                    w_state_nx = S_TX;
                    w_ph_nx    = 2'd0;
                    w_bit_nx   = 3'd0;
                    w_byte_nx  = 2'd0;
                    w_shift_nx = {r_dev, 1'b0};
                end
            end
            S_TX, S_RXACK, S_RX, S_TXNACK: if (w_tick) begin
                // phase B holds while a slave stretches SCL
                if (r_ph == 2'd1) begin
                    if (scl_in) w_ph_nx = 2'd2;
                end else if (r_ph != 2'd3) begin
                    w_ph_nx = r_ph + 2'd1;
                end else begin
                    w_ph_nx = 2'd0;
                    case (r_state)
                        S_TX: begin
                            if (r_bit == 3'd7) w_state_nx = S_RXACK;
                            else begin
                                w_bit_nx   = r_bit + 3'd1;
                                w_shift_nx = {r_shift[6:0], 1'b0};
                            end
                        end
                        S_RXACK: begin
                            w_bit_nx = 3'd0;
                            if (r_nack) begin
                                w_state_nx  = S_STOP;
                                w_nack_stop = 1'b1;
                            end else if (r_byte == 2'd0) begin
                                w_state_nx = S_TX;
                                w_byte_nx  = 2'd1;
                                w_shift_nx = r_reg;
                            end else if (r_byte == 2'd1 && !r_rw) begin
                                w_state_nx = S_TX;
                                w_byte_nx  = 2'd2;
                                w_shift_nx = r_wdata;
                            end else if (r_byte == 2'd1) begin
                                w_state_nx = S_RSTART;
                            end else if (r_rw) begin
                                w_state_nx = S_RX;
                            end else begin
                                w_state_nx = S_STOP;
                            end
                        end
                        S_RX: begin
                            if (r_bit == 3'd7) w_state_nx = S_TXNACK;
                            else w_bit_nx = r_bit + 3'd1;
                        end
                        default: w_state_nx = S_STOP;
                    endcase
                end
            end
            S_RSTART: if (w_tick) begin
                if (r_ph == 2'd1) begin
                    if (scl_in) w_ph_nx = 2'd2;
                end else if (r_ph != 2'd3) begin
                    w_ph_nx = r_ph + 2'd1;
                end else begin
                    w_state_nx = S_TX;
                    w_ph_nx    = 2'd0;
                    w_bit_nx   = 3'd0;
                    w_byte_nx  = 2'd2;
                    w_shift_nx = {r_dev, 1'b1};
                end
            end
            S_STOP: if (w_tick) begin
                if (r_ph == 2'd3) begin
                    w_state_nx = S_IDLE;
                    w_done_nx  = 1'b1;
                end else begin
                    w_ph_nx = r_ph + 2'd1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        // line drive for the quarter being entered; registered so pins move only on ticks
        w_scl_nx = 1'b0;
        w_sda_nx = 1'b0;
        case (w_state_nx)
            S_START: begin
                w_sda_nx = 1'b1;
                w_scl_nx = (w_ph_nx == 2'd1);
            end
            S_TX, S_RXACK, S_RX, S_TXNACK: begin
                w_scl_nx = (w_ph_nx == 2'd0) || (w_ph_nx == 2'd3);
                w_sda_nx = (w_state_nx == S_TX) && !w_shift_nx[7];
            end
            S_RSTART: begin
                w_scl_nx = (w_ph_nx == 2'd0) || (w_ph_nx == 2'd3);
                w_sda_nx = w_ph_nx[1];
            end
            S_STOP: begin
                w_scl_nx = (w_ph_nx == 2'd0);
                w_sda_nx = !w_ph_nx[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_qcnt    <= '0;
            r_ph      <= 2'd0;
            r_bit     <= 3'd0;
            r_byte    <= 2'd0;
            r_shift   <= 8'd0;
            r_rw      <= 1'b0;
            r_dev     <= 7'd0;
            r_reg     <= 8'd0;
            r_wdata   <= 8'd0;
            r_rx      <= 8'd0;
            r_rdata   <= 8'd0;
            r_nack    <= 1'b0;
            r_ack_err <= 1'b0;
            r_done    <= 1'b0;
            r_scl_oe  <= 1'b0;
            r_sda_oe  <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_ph     <= w_ph_nx;
            r_bit    <= w_bit_nx;
            r_byte   <= w_byte_nx;
            r_shift  <= w_shift_nx;
            r_done   <= w_done_nx;
            r_scl_oe <= w_scl_nx;
            r_sda_oe <= w_sda_nx;
            if (r_state == S_IDLE || w_tick) r_qcnt <= '0;
            else r_qcnt <= r_qcnt + 1'b1;
            if (r_state == S_IDLE && start) begin
                r_rw      <= rw;
                r_dev     <= dev_addr;
                r_reg     <= reg_addr;
                r_wdata   <= wdata;
                r_ack_err <= 1'b0;
            end
            if (w_tick && r_ph == 2'd2 && r_state == S_RXACK) r_nack <= sda_in;
            if (w_tick && r_ph == 2'd2 && r_state == S_RX) r_rx <= {r_rx[6:0], sda_in};
            if (w_nack_stop) r_ack_err <= 1'b1;
            if (w_done_nx && r_rw && !r_ack_err) r_rdata <= r_rx;
        end
    end
endmodule

// File: tb/tb_i2c_register_master.sv
// Randomized bench for i2c_register_master: a behavioural I2C slave on the bus and a
// transaction-level model of expected bus bytes, done latency, ack_error and rdata.
module tb_i2c_register_master;
    localparam int CD = 4;

    logic       clk, reset, start, rw;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr, wdata;
    logic       ready, done, ack_error, scl_oe, sda_oe;
    logic [7:0] rdata;
    logic       scl_line, sda_line;

    // slave model state and its configuration
    logic       slv_hold = 1'b0, slv_sda = 1'b0, slv_stretch = 1'b0;
    int         slv_nack_at = 0;
    logic [7:0] slv_rbyte = 8'h00;
    int         log_q[$];
    int         exp_q[$];

    int         cyc = 0;
    int         n_vec = 0, n_miscmp = 0;
    logic [7:0] model_rdata = 8'h00;

    assign scl_line = !(scl_oe || slv_hold);
    assign sda_line = !(sda_oe || slv_sda);

    i2c_register_master #(.CLK_DIV(CD)) dut (
        .clk(clk), .reset(reset), .start(start), .rw(rw),
        .dev_addr(dev_addr), .reg_addr(reg_addr), .wdata(wdata),
        .ready(ready), .done(done), .ack_error(ack_error), .rdata(rdata),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_in(scl_line), .sda_in(sda_line)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Behavioural slave: logs START(-1), STOP(-2), received bytes, and 1000+master ack bit.
    initial begin
        logic p_scl, p_sda, c_scl, c_sda, first, go_tx, tx_mode;
        logic [7:0] shreg;
        int bitcnt, byte_no, hcnt;
        p_scl = 1; p_sda = 1; first = 0; go_tx = 0; tx_mode = 0;
        shreg = 0; bitcnt = 0; byte_no = 0; hcnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                p_scl = 1; p_sda = 1; first = 0; go_tx = 0; tx_mode = 0;
                bitcnt = 0; byte_no = 0; slv_sda = 0; slv_hold = 0;
            end else begin
                c_scl = scl_line;
                c_sda = sda_line;
                if (slv_hold) begin
                    // stretch 50 cycles past where phase B would normally end
                    if (!scl_oe) hcnt++;
                    if (hcnt >= 50 + CD) slv_hold = 0;
                end
                if (p_scl && c_scl && p_sda && !c_sda) begin
                    log_q.push_back(-1);
                    bitcnt = 0; first = 1; tx_mode = 0; go_tx = 0;
                end else if (p_scl && c_scl && !p_sda && c_sda) begin
                    log_q.push_back(-2);
                    bitcnt = 0; tx_mode = 0; go_tx = 0; byte_no = 0;
                end else if (!p_scl && c_scl) begin
                    if (bitcnt < 8) begin
                        if (!tx_mode) shreg = {shreg[6:0], c_sda};
                        bitcnt++;
                    end else begin
                        if (tx_mode) log_q.push_back(1000 + int'(c_sda));
                        bitcnt = 9;
                    end
                end else if (p_scl && !c_scl) begin
                    if (bitcnt == 8) begin
                        if (tx_mode) slv_sda = 0;
                        else begin
                            log_q.push_back(int'(shreg));
                            byte_no++;
                            slv_sda = (byte_no != slv_nack_at);
                            go_tx = first && shreg[0] && slv_sda;
                            first = 0;
                        end
                    end else if (bitcnt == 9) begin
                        bitcnt = 0; slv_sda = 0; tx_mode = 0;
                        if (go_tx) begin
                            go_tx = 0; tx_mode = 1; slv_sda = !slv_rbyte[7];
                        end
                    end else if (tx_mode && bitcnt > 0) begin
                        slv_sda = !slv_rbyte[7 - bitcnt];
                    end
                    if (slv_stretch && byte_no == 0 && !tx_mode && bitcnt == 2 && !slv_hold) begin
                        slv_hold = 1; hcnt = 0;
                    end
                end
                p_scl = c_scl;
                p_sda = c_sda;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Quarters from accept to done, straight from the protocol's bit/byte counts.
    function automatic int quarters(input bit r, input int k);
        if (k == 0) return r ? 154 : 114;
        return 2 + 36 * k + ((r && k == 3) ? 4 : 0) + 4;
    endfunction

    task automatic push_exp(input bit r, input logic [6:0] d, input logic [7:0] ra,
                            input logic [7:0] w, input int k);
        exp_q.push_back(-1);
        exp_q.push_back(int'({d, 1'b0}));
        if (k == 1) begin exp_q.push_back(-2); return; end
        exp_q.push_back(int'(ra));
        if (k == 2) begin exp_q.push_back(-2); return; end
        if (!r) begin
            exp_q.push_back(int'(w));
            exp_q.push_back(-2);
            return;
        end
        exp_q.push_back(-1);
        exp_q.push_back(int'({d, 1'b1}));
        if (k != 3) exp_q.push_back(1001);
        exp_q.push_back(-2);
    endtask

    task automatic wait_done(input int acc, output int lat);
        while (!done && (cyc - acc) < 3000) @(negedge clk);
        chk("done_seen", done, 1);
        lat = cyc - acc;
    endtask

    task automatic check_log(input int base);
        chk("log_len", log_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++)
            chk("bus_log", log_q[base + i], exp_q[i]);
    endtask

    task automatic run_txn(input bit r, input logic [6:0] d, input logic [7:0] ra,
                           input logic [7:0] w, input int k, input logic [7:0] sb,
                           input bit stretch, input bit poke);
        int base, acc, lat, guard;
        logic [7:0] rd_exp;
        slv_nack_at = k; slv_rbyte = sb; slv_stretch = stretch;
        base = log_q.size();
        exp_q.delete();
        push_exp(r, d, ra, w, k);
        rd_exp = (r && k == 0) ? sb : model_rdata;
        guard = 0;
        while (!ready && guard < 1000) begin @(negedge clk); guard++; end
        rw = r; dev_addr = d; reg_addr = ra; wdata = w; start = 1;
        @(negedge clk);
        acc = cyc; start = 0;
        chk("accept_busy", ready, 0);
        if (poke) begin
            repeat (40) @(negedge clk);
            start = 1; dev_addr = ~d; rw = ~r;
            @(negedge clk);
            start = 0;
        end
        wait_done(acc, lat);
        if (stretch) chk("stretch_delay_50_53",
                         (lat - quarters(r, k) * CD >= 50) && (lat - quarters(r, k) * CD <= 53), 1);
        else chk("done_latency", lat, quarters(r, k) * CD);
        chk("ready_at_done", ready, 1);
        chk("ack_error", ack_error, (k != 0));
        chk("rdata", rdata, rd_exp);
        model_rdata = rd_exp;
        @(negedge clk);
        chk("done_pulse", done, 0);
        slv_stretch = 0;
        check_log(base);
    endtask

    initial begin
        int base, acc, lat, k;
        bit r;
        reset = 1; start = 0; rw = 0; dev_addr = 0; reg_addr = 0; wdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_scl_oe", scl_oe, 0);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_ack_error", ack_error, 0);
        chk("rst_rdata", rdata, 0);
        reset = 0;
        @(negedge clk);

        run_txn(0, 7'h39, 8'h41, 8'h10, 0, 8'h00, 0, 0);
        run_txn(1, 7'h39, 8'h00, 8'h00, 0, 8'h80, 0, 0);
        run_txn(0, 7'h39, 8'h41, 8'h10, 1, 8'h00, 0, 0);
        run_txn(1, 7'h50, 8'h12, 8'h00, 2, 8'h5a, 0, 0);
        run_txn(1, 7'h33, 8'h7e, 8'h00, 3, 8'hc4, 0, 0);
        run_txn(0, 7'h22, 8'h01, 8'hc3, 0, 8'h00, 1, 0);
        run_txn(0, 7'h2a, 8'h07, 8'h99, 0, 8'h00, 0, 1);

        // reset partway into the address byte, while SCL is held low
        slv_nack_at = 0;
        rw = 0; dev_addr = 7'h11; reg_addr = 8'h22; wdata = 8'h33; start = 1;
        @(negedge clk);
        start = 0;
        repeat (36) @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("midrst_scl_oe", scl_oe, 0);
        chk("midrst_sda_oe", sda_oe, 0);
        chk("midrst_ready", ready, 1);
        chk("midrst_rdata", rdata, 0);
        model_rdata = 8'h00;
        reset = 0;
        @(negedge clk);
        run_txn(1, 7'h11, 8'h22, 8'h00, 0, 8'h6d, 0, 0);

        // back-to-back: start held high through the first done
        slv_nack_at = 0;
        base = log_q.size();
        exp_q.delete();
        push_exp(0, 7'h45, 8'h10, 8'hab, 0);
        push_exp(0, 7'h46, 8'h20, 8'hcd, 0);
        rw = 0; dev_addr = 7'h45; reg_addr = 8'h10; wdata = 8'hab; start = 1;
        @(negedge clk);
        acc = cyc;
        dev_addr = 7'h46; reg_addr = 8'h20; wdata = 8'hcd;
        wait_done(acc, lat);
        chk("b2b_latency1", lat, 114 * CD);
        @(negedge clk);
        acc = cyc;
        chk("b2b_accept", ready, 0);
        start = 0;
        wait_done(acc, lat);
        chk("b2b_latency2", lat, 114 * CD);
        @(negedge clk);
        check_log(base);

        for (int i = 0; i < 20; i++) begin
            r = 1'($urandom_range(0, 1));
            k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_txn(r, 7'($urandom), 8'($urandom), 8'($urandom), k, 8'($urandom), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
